// File: rtl/ysyx_22040088_pkg.sv
// rtl/ysyx_22040088_pkg.sv - shared widths and requester identifiers for the writeback arbiter
package ysyx_22040088_pkg;

  localparam int XLEN  = 64;
  localparam int NREG  = 32;
  localparam int REG_W = $clog2(NREG);

  // Requester identity, also used as the round-robin "last granted" pointer
  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/ysyx_22040088_rr_arb2.sv
// rtl/ysyx_22040088_rr_arb2.sv - two-way round-robin arbiter, bit 0 = EXU, bit 1 = LSU
module ysyx_22040088_rr_arb2
  import ysyx_22040088_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_q;
  req_id_e last_d;

  // Grant a lone requester; on a tie grant whoever did not win last time
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == REQ_EXU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      last_d = REQ_EXU;
    end else if (gnt[1]) begin
      last_d = REQ_LSU;
    end
  end

  // Pointer starts at LSU so EXU wins the first tie after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ysyx_22040088_rf_wb_arbiter.sv
// rtl/ysyx_22040088_rf_wb_arbiter.sv - register-file writeback arbiter with busy-bit scoreboard
module ysyx_22040088_rf_wb_arbiter
  import ysyx_22040088_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREG_P = NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_rd,
  output logic              iss_ready,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              exu_valid,
  input  logic [REG_W-1:0]  exu_rd,
  input  logic [XLEN_P-1:0] exu_data,
  output logic              exu_ready,
  input  logic              lsu_valid,
  input  logic [REG_W-1:0]  lsu_rd,
  input  logic [XLEN_P-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              flush,
  output logic              rf_wen,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [XLEN_P-1:0] rf_wdata,
  output logic [5:0]        pend_cnt
);

  logic [NREG_P-1:0] busy_q, busy_d;
  logic              rf_wen_q, rf_wen_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [XLEN_P-1:0] rf_wdata_q, rf_wdata_d;
  logic [5:0]        pend_cnt_q, pend_cnt_d;

  logic [1:0]        arb_req;
  logic [1:0]        arb_gnt;
  logic              iss_fire;
  logic [REG_W-1:0]  wb_rd;
  logic [XLEN_P-1:0] wb_data;

  // Flush suppresses every grant so nothing new reaches the write port
  assign arb_req = {lsu_valid & ~flush, exu_valid & ~flush};

  ysyx_22040088_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (arb_gnt)
  );

  assign exu_ready = arb_gnt[0];
  assign lsu_ready = arb_gnt[1];

  // Issue is blocked while the destination already has a pending writer
  assign iss_ready = ~flush & ((iss_rd == '0) | ~busy_q[iss_rd]);
  assign iss_fire  = iss_valid & iss_ready & (iss_rd != '0);

  // Source lookups see registered state only
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pend_cnt = pend_cnt_q;

  // Mux the granted requester onto the write-port inputs
  always_comb begin
    wb_rd   = exu_rd;
    wb_data = exu_data;
    if (arb_gnt[1]) begin
      wb_rd   = lsu_rd;
      wb_data = lsu_data;
    end
  end

  // Write-port register: load on grant, pulse wen only for non-zero rd
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (arb_gnt != 2'b00) begin
      rf_wen_d   = (wb_rd != '0);
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end
  end

  // Scoreboard: clear on the visible write, then set on issue so a same-register set wins
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (iss_fire) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Pending count tracks the next busy vector so it moves in step with the bits
  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NREG_P; i++) begin
      pend_cnt_d = pend_cnt_d + 6'(busy_d[i]);
    end
  end

  // State registers; reset drops any in-flight write and all pending writers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_rf_wb_arbiter.sv
// tb/tb_ysyx_22040088_rf_wb_arbiter.sv - directed scoreboard bench for the writeback arbiter
module tb_ysyx_22040088_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [63:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        lsu_ready;
  logic        flush;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [5:0]  pend_cnt;

  ysyx_22040088_rf_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .exu_valid (exu_valid),
    .exu_rd    (exu_rd),
    .exu_data  (exu_data),
    .exu_ready (exu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .flush     (flush),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_exp_t;

  wb_exp_t     exp_q[$];
  int          total = 0;
  int          bad   = 0;

  logic [31:0] m_busy;
  logic        m_last;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [1:0]  grant_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    exu_valid = 1'b0; exu_rd = 5'd0; exu_data = 64'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 64'd0;
    flush = 1'b0;
  endtask

  task automatic model_reset();
    m_busy  = 32'd0;
    m_last  = 1'b1;
    m_wen   = 1'b0;
    m_waddr = 5'd0;
    exp_q.delete();
  endtask

  // One clock: check combinational outputs against the model, push the expected
  // write, then after the edge pop it and compare the write port and count.
  task automatic tick();
    logic    e_iss, g_e, g_l;
    logic [4:0]  g_rd;
    logic [63:0] g_d;
    wb_exp_t e, o;
    @(negedge clk);
    e_iss = !flush && (iss_rd == 5'd0 || !m_busy[iss_rd]);
    check("iss_ready", iss_ready, e_iss);
    check("rs1_busy", rs1_busy, m_busy[rs1]);
    check("rs2_busy", rs2_busy, m_busy[rs2]);
    g_e = 1'b0; g_l = 1'b0;
    if (!flush) begin
      if (exu_valid && lsu_valid) begin
        if (m_last) g_e = 1'b1; else g_l = 1'b1;
      end else begin
        g_e = exu_valid;
        g_l = lsu_valid;
      end
    end
    check("exu_ready", exu_ready, g_e);
    check("lsu_ready", lsu_ready, g_l);
    check("one_hot_ready", exu_ready & lsu_ready, 1'b0);
    grant_log.push_back({g_l, g_e});
    g_rd = g_l ? lsu_rd : exu_rd;
    g_d  = g_l ? lsu_data : exu_data;
    e.wen  = (g_e || g_l) && g_rd != 5'd0;
    e.addr = g_rd;
    e.data = g_d;
    exp_q.push_back(e);
    if (m_wen) m_busy[m_waddr] = 1'b0;
    if (iss_valid && e_iss && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    if (flush) m_busy = 32'd0;
    if (g_e) m_last = 1'b0;
    if (g_l) m_last = 1'b1;
    m_wen   = e.wen;
    m_waddr = g_rd;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      o = exp_q.pop_front();
      check("rf_wen", rf_wen, o.wen);
      if (o.wen) begin
        check("rf_waddr", rf_waddr, o.addr);
        check("rf_wdata", rf_wdata, o.data);
      end
    end
    check("pend_cnt", pend_cnt, $countones(m_busy));
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_rf_waddr", rf_waddr, 5'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_pend_cnt", pend_cnt, 6'd0);
    rst = 1'b0;

    // Tie for four cycles right after reset: EXU, LSU, EXU, LSU
    grant_log.delete();
    exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 64'h1010;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 64'h1111;
    repeat (4) tick();
    check("rr_g0", grant_log[0], 2'b01);
    check("rr_g1", grant_log[1], 2'b10);
    check("rr_g2", grant_log[2], 2'b01);
    check("rr_g3", grant_log[3], 2'b10);
    idle();
    tick();

    // Issue rd5, read it busy, EXU writes 0xDEAD, busy clears
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    idle(); rs1 = 5'd5;
    tick();
    check("rd5_busy", rs1_busy, 1'b1);
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 64'hDEAD;
    tick();
    check("wb5_wen", rf_wen, 1'b1);
    check("wb5_addr", rf_waddr, 5'd5);
    check("wb5_data", rf_wdata, 64'hDEAD);
    exu_valid = 1'b0;
    tick();
    tick();
    check("rd5_clear", rs1_busy, 1'b0);
    check("rd5_pend", pend_cnt, 6'd0);

    // WAW block on rd7, then release after the write retires
    idle(); rs2 = 5'd7;
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 64'h7777;
    tick();
    exu_valid = 1'b0;
    tick();
    tick();
    iss_valid = 1'b0;
    check("rd7_reissued", rs2_busy, 1'b1);
    exu_valid = 1'b1;
    tick();
    exu_valid = 1'b0;
    tick();
    check("rd7_cleared", rs2_busy, 1'b0);
    // Stray write to idle rd7 retiring in the same cycle as a new issue of rd7
    exu_valid = 1'b1; exu_data = 64'h7070;
    tick();
    exu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    tick();
    check("rd7_set_wins", rs2_busy, 1'b1);

    // rd0 writeback: no write, pointer still moves (last=EXU so tie goes LSU)
    idle();
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 64'hFF;
    tick();
    check("rd0_no_wen", rf_wen, 1'b0);
    grant_log.delete();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h5A5A;
    tick();
    check("rd0_ptr_adv", grant_log[0], 2'b10);
    idle();
    tick();

    // Busy 3,4,9 then flush with EXU valid
    iss_valid = 1'b1;
    iss_rd = 5'd3; tick();
    iss_rd = 5'd4; tick();
    iss_rd = 5'd9; tick();
    idle();
    check("pend3", pend_cnt, 6'd3);
    flush = 1'b1; exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 64'h33;
    tick();
    check("flush_pend", pend_cnt, 6'd0);
    check("flush_wen", rf_wen, 1'b0);
    idle(); rs1 = 5'd9;
    tick();
    check("flush_busy9", rs1_busy, 1'b0);

    // Asynchronous reset while a write is on the port
    iss_valid = 1'b1; iss_rd = 5'd12;
    tick();
    idle();
    exu_valid = 1'b1; exu_rd = 5'd12; exu_data = 64'hC0C0;
    tick();
    idle();
    check("pre_rst_wen", rf_wen, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_wen", rf_wen, 1'b0);
    check("async_rst_pend", pend_cnt, 6'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_rf_wb_arbiter.md
YSYX_22040088_RF_WB_ARBITER -- requirements
Module: ysyx_22040088_rf_wb_arbiter

Interface
REQ-001 Parameter XLEN, 64, writeback data width.
REQ-002 Parameter NREG, 32, architectural register count; register index width is log2(NREG)=5.
REQ-003 Reset is asynchronous and active-high; the block uses one clock.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 iss_valid  in  1  decode issues an instruction that writes iss_rd.
REQ-007 iss_rd  in  5  destination register of the issuing instruction.
REQ-008 iss_ready  out  1  issue accepted this cycle (combinational).
REQ-009 rs1, rs2  in  5 each  source registers queried by decode.
REQ-010 rs1_busy, rs2_busy  out  1 each  source has a pending writer (combinational).
REQ-011 exu_valid, exu_rd, exu_data  in  1/5/XLEN  EXU writeback request.
REQ-012 exu_ready  out  1  EXU request granted.
REQ-013 lsu_valid, lsu_rd, lsu_data  in  1/5/XLEN  LSU writeback request.
REQ-014 lsu_ready  out  1  LSU request granted.
REQ-015 flush  in  1  pipeline flush; discards all pending writer state.
REQ-016 rf_wen, rf_waddr, rf_wdata  out  1/5/XLEN  registered drive of the register-file write port.
REQ-017 pend_cnt  out  6  number of set busy bits.

Function
REQ-018 Scoreboard: 32 busy bits; bit 0 is constant 0 and is never set.
REQ-019 iss_ready = flush==0 and (iss_rd==0 or busy[iss_rd]==0); this blocks WAW hazards.
REQ-020 Issue handshake: iss_valid and iss_ready with iss_rd!=0 sets busy[iss_rd] at the next edge.
REQ-021 rsN_busy = busy[rsN]; it does not bypass a same-cycle clear (that is, it reflects registered state).
REQ-022 Arbitration between EXU and LSU is 2-way round-robin:
- a single valid requester is granted;
- when both are valid, the requester not granted last is granted;
- the last-grant pointer updates only on a grant.
REQ-023 At most one of exu_ready and lsu_ready is high per cycle.
REQ-024 Both readys are 0 while flush=1.
REQ-025 Readys are combinational from the valids and the pointer.
REQ-026 Requesters hold rd and data stable while valid and not ready.
REQ-027 Latency: a grant in cycle N produces rf_wen=1 in cycle N+1, with the granted rd and data.
REQ-028 A grant with rd==0 produces rf_wen=0 in N+1 and still advances the pointer.
REQ-029 With no grant, rf_wen=0 next cycle; rf_waddr and rf_wdata hold their previous values.
REQ-030 busy[rf_waddr] clears at the edge ending the cycle in which rf_wen=1, so the clear coincides with the register-file write.
REQ-031 A simultaneous set (issue) and clear (rf_wen) of the same register: set wins.
REQ-032 flush=1 clears all busy bits and forces rf_wen=0 next cycle.
REQ-033 Under flush, an rf_wen=1 already on the outputs in the flush cycle still completes.
REQ-034 pend_cnt is a registered population count, updated consistently with the busy bits; range 0..31.

Reset
REQ-035 rst=1 immediately clears all busy bits, pend_cnt=0, rf_wen=0, rf_waddr=0, rf_wdata=0, and sets the pointer so that EXU wins the first tie.
REQ-036 Reset mid-writeback drops the pending write; no busy bit survives reset.

Structure
REQ-037 The shared package ysyx_22040088_pkg holds XLEN, NREG, the register index width and the requester-ID constants (REQ_EXU=0, REQ_LSU=1).
REQ-038 The sub-module ysyx_22040088_rr_arb2 holds the 2-way round-robin arbiter: req[1:0] in, gnt[1:0] out, pointer register.
REQ-039 The scoreboard, write-port register and counter live in the top module.

Verification
REQ-040 Issue rd=5 → rs1=5 gives rs1_busy=1 next cycle; EXU wb rd=5, data=0xDEAD granted → cycle+1: rf_wen=1, rf_waddr=5, rf_wdata=0xDEAD; cycle+2: rs1_busy=0, pend_cnt=0.
REQ-041 EXU and LSU valid together for 4 cycles after reset → grants alternate EXU, LSU, EXU, LSU; never both ready.
REQ-042 Issue rd=7 while busy[7]=1 → iss_ready=0; after the rd=7 write completes → iss_ready=1; issue in the same cycle as rf_wen for rd=7 → busy[7] stays 1.
REQ-043 Writeback with rd=0, data=0xFF → rf_wen=0 next cycle, pend_cnt unchanged, pointer advanced.
REQ-044 Busy rd=3,4,9 (pend_cnt=3), then flush=1 with EXU valid → exu_ready=0, next cycle all busy bits=0, pend_cnt=0, rf_wen=0.
REQ-045 Assert rst asynchronously mid-cycle with rf_wen=1 → rf_wen=0 and pend_cnt=0 immediately, without waiting for a clock edge.
